// File: rtl/alarm_pkg.sv
// Shared types and widths for the VGA clock alarm sequencer.
package alarm_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } alarm_state_t;

    localparam int unsigned HOUR_W = 4;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;

    // Counter width able to hold 0..limit-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/alarm_sequencer_tone_gen.sv
// Free-running square-wave divider producing the buzzer tone.
module tone_gen
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_DIV = 5000
) (
    input  logic video_clk,
    input  logic reset,
    output logic tone
);

    localparam int unsigned        CNT_W   = cnt_width(TONE_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TONE_DIV - 1);

    logic [CNT_W-1:0] tone_cnt;

    always_ff @(posedge video_clk) begin
        if (reset) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (tone_cnt == CNT_MAX) begin
            tone_cnt <= '0;
            tone     <= ~tone;
        end else begin
            tone_cnt <= tone_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm FSM (OFF/ARMED/RINGING/SNOOZE), ring cadence and buzzer gating.
// Build option ALARM_ESCALATE_EN: ringing becomes continuous after ESCALATE_S seconds.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_DIV       = 5000,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned SNOOZE_S       = 300
`ifdef ALARM_ESCALATE_EN
    ,
    parameter int unsigned ESCALATE_S     = 30
`endif
) (
    input  logic              video_clk,
    input  logic              reset,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] hours,
    input  logic [MIN_W-1:0]  minutes,
    input  logic [SEC_W-1:0]  seconds,
    input  logic [HOUR_W-1:0] al_hours,
    input  logic [MIN_W-1:0]  al_minutes,
    input  logic              toggle_pulse,
    input  logic              snooze_pulse,
    output logic              al_on,
    output logic              ringing,
    output logic              snoozing,
    output logic              buzzer_out
);

    localparam int unsigned       RING_W    = cnt_width(RING_TIMEOUT_S);
    localparam int unsigned       SNZ_W     = cnt_width(SNOOZE_S);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_S - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_S - 1);
`ifdef ALARM_ESCALATE_EN
    localparam logic [RING_W-1:0] ESC_AT    = RING_W'(ESCALATE_S - 1);
`endif

    alarm_state_t      state, state_n;
    logic [RING_W-1:0] ring_cnt, ring_cnt_n;
    logic [SNZ_W-1:0]  snz_cnt, snz_cnt_n;
    logic              beep_gate, beep_gate_n;
    logic              match, match_q, trig;
    logic              tone;

    tone_gen #(.TONE_DIV(TONE_DIV)) u_tone_gen (
        .video_clk (video_clk),
        .reset     (reset),
        .tone      (tone)
    );

    // Rising edge of the alarm-time match so a held match fires only once.
    assign match = (hours == al_hours) && (minutes == al_minutes) && (seconds == SEC_W'(0));
    assign trig  = match && !match_q;

    always_comb begin
        state_n     = state;
        ring_cnt_n  = ring_cnt;
        snz_cnt_n   = snz_cnt;
        beep_gate_n = beep_gate;
        case (state)
            OFF: begin
                if (toggle_pulse) state_n = ARMED;
            end
            ARMED: begin
                if (toggle_pulse) begin
                    state_n = OFF;
                end else if (trig) begin
                    state_n     = RINGING;
                    ring_cnt_n  = '0;
                    beep_gate_n = 1'b1;
                end
            end
            RINGING: begin
                if (toggle_pulse) begin
                    state_n = OFF;
                end else if (snooze_pulse) begin
                    state_n   = SNOOZE;
                    snz_cnt_n = '0;
                end else if (tick_1hz) begin
                    if (ring_cnt == RING_LAST) begin
                        state_n = ARMED;
                    end else begin
                        ring_cnt_n  = ring_cnt + RING_W'(1);
                        beep_gate_n = ~beep_gate;
                    end
                end
            end
            SNOOZE: begin
                if (toggle_pulse) begin
                    state_n = OFF;
                end else if (tick_1hz) begin
                    if (snz_cnt == SNZ_LAST) begin
                        state_n     = RINGING;
                        ring_cnt_n  = '0;
                        beep_gate_n = 1'b1;
                    end else begin
                        snz_cnt_n = snz_cnt + SNZ_W'(1);
                    end
                end
            end
            default: state_n = OFF;
        endcase
`ifdef ALARM_ESCALATE_EN
        // Past the escalation point the gate stays open for the rest of this ring.
        if ((state_n == RINGING) && (ring_cnt_n >= ESC_AT)) beep_gate_n = 1'b1;
`endif
    end

    // Buzzer is also cut on the exit edge so it drops together with the status bits.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            state      <= OFF;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
            beep_gate  <= 1'b0;
            match_q    <= 1'b0;
            buzzer_out <= 1'b0;
            al_on      <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= state_n;
            ring_cnt   <= ring_cnt_n;
            snz_cnt    <= snz_cnt_n;
            beep_gate  <= beep_gate_n;
            match_q    <= match;
            buzzer_out <= (state == RINGING) && (state_n == RINGING) && beep_gate && tone;
            al_on      <= (state_n != OFF);
            ringing    <= (state_n == RINGING);
            snoozing   <= (state_n == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed table and sequence bench for alarm_sequencer (honours ALARM_ESCALATE_EN).
module tb_alarm_sequencer;

    typedef struct packed {
        logic       toggle;
        logic       snooze;
        logic       tick;
        logic [3:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [2:0] exp;   // {al_on, ringing, snoozing}
    } vec_t;

    logic       video_clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] hours, al_hours;
    logic [5:0] minutes, seconds, al_minutes;
    logic       toggle_pulse, snooze_pulse;
    logic       al_on, ringing, snoozing, buzzer_out;

    int total  = 0;
    int passed = 0;

    vec_t vecs [28];

    always #5 video_clk = ~video_clk;

    alarm_sequencer #(
        .TONE_DIV       (4),
        .RING_TIMEOUT_S (5),
        .SNOOZE_S       (3)
`ifdef ALARM_ESCALATE_EN
        , .ESCALATE_S   (2)
`endif
    ) dut (
        .video_clk    (video_clk),
        .reset        (reset),
        .tick_1hz     (tick),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .al_hours     (al_hours),
        .al_minutes   (al_minutes),
        .toggle_pulse (toggle_pulse),
        .snooze_pulse (snooze_pulse),
        .al_on        (al_on),
        .ringing      (ringing),
        .snoozing     (snoozing),
        .buzzer_out   (buzzer_out)
    );

    function automatic vec_t v(input bit tg, input bit sn, input bit tk,
                               input int h, input int m, input int s, input logic [2:0] e);
        vec_t r;
        r.toggle = tg; r.snooze = sn; r.tick = tk;
        r.h = 4'(h); r.m = 6'(m); r.s = 6'(s); r.exp = e;
        return r;
    endfunction

    // Expected gate for the k-th second of a ring (k = 0 is the entry second).
    function automatic bit gate_on(input int k);
`ifdef ALARM_ESCALATE_EN
        return (k >= 0);
`else
        return (k % 2) == 0;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge video_clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours = 4'(h); minutes = 6'(m); seconds = 6'(s);
    endtask

    // One second: 19 idle cycles (buzzer sampled on 18 of them) then a tick cycle.
    task automatic one_second(input bit exp_on, input string name);
        logic smp [18];
        int   n = 0, highs = 0, runs = 0, bad = 0, len = 1;
        bit   seen = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            tick = 1'b0;
            step();
            if (i >= 2) begin
                smp[n] = buzzer_out;
                if (buzzer_out) highs++;
                n++;
            end
        end
        tick = 1'b1;
        step();
        tick = 1'b0;
        if (!exp_on) begin
            chk({name, "_silent"}, highs, 0);
        end else begin
            for (int j = 1; j < 18; j++) begin
                if (smp[j] != smp[j-1]) begin
                    if (seen) begin
                        runs++;
                        if (len != 4) bad++;
                    end
                    seen = 1'b1;
                    len  = 1;
                end else begin
                    len++;
                end
            end
            chk({name, "_badruns"}, bad, 0);
            chk({name, "_enough_runs"}, int'(runs >= 3), 1);
        end
    endtask

    task automatic trigger_ring(input string name);
        set_time(3, 15, 1);
        step();
        set_time(3, 15, 0);
        step();
        chk({name, "_ringing"}, int'(ringing), 1);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; toggle_pulse = 1'b0; snooze_pulse = 1'b0;
        al_hours = 4'd3; al_minutes = 6'd15;
        set_time(3, 14, 59);

        vecs[0]  = v(0,0,0, 3,14,59, 3'b000);
        vecs[1]  = v(0,0,1, 3,15, 0, 3'b000);   // match while OFF ignored
        vecs[2]  = v(1,0,0, 3,15, 0, 3'b100);   // arm inside matching second: no trig
        vecs[3]  = v(0,0,0, 3,15, 0, 3'b100);
        vecs[4]  = v(0,0,0, 3,15, 1, 3'b100);
        vecs[5]  = v(0,0,1, 3,15, 0, 3'b110);   // rising match -> ring
        vecs[6]  = v(0,0,1, 3,15, 1, 3'b110);
        vecs[7]  = v(0,1,0, 3,15, 1, 3'b101);   // snooze
        vecs[8]  = v(0,1,0, 3,15, 1, 3'b101);   // snooze again ignored
        vecs[9]  = v(0,0,1, 3,15, 1, 3'b101);
        vecs[10] = v(0,0,1, 3,15, 1, 3'b101);
        vecs[11] = v(0,0,1, 3,15, 1, 3'b110);   // 3rd snooze tick -> ring
        vecs[12] = v(1,1,0, 3,15, 1, 3'b000);   // toggle beats snooze
        vecs[13] = v(0,1,1, 3,15, 1, 3'b000);
        vecs[14] = v(1,0,0, 3,15, 1, 3'b100);
        vecs[15] = v(1,0,0, 3,15, 0, 3'b000);   // toggle beats trig
        vecs[16] = v(1,0,0, 3,15, 0, 3'b100);
        vecs[17] = v(0,0,0, 3,16, 0, 3'b100);   // minute mismatch
        vecs[18] = v(0,0,0, 4,15, 0, 3'b100);   // hour mismatch
        vecs[19] = v(0,0,0, 3,15, 0, 3'b110);
        vecs[20] = v(0,0,1, 3,15, 0, 3'b110);
        vecs[21] = v(0,0,1, 3,15, 0, 3'b110);
        vecs[22] = v(0,0,1, 3,15, 0, 3'b110);
        vecs[23] = v(0,0,1, 3,15, 0, 3'b110);
        vecs[24] = v(0,0,1, 3,15, 0, 3'b100);   // 5th tick -> timeout to ARMED
        vecs[25] = v(0,0,0, 3,15, 0, 3'b100);   // held match, no retrigger
        vecs[26] = v(0,1,0, 3,15, 0, 3'b100);   // snooze while ARMED ignored
        vecs[27] = v(0,0,1, 3,15, 0, 3'b100);

        step();
        step();
        chk("reset_outputs", int'({al_on, ringing, snoozing, buzzer_out}), 0);
        reset = 1'b0;

        // Table-driven state transitions.
        foreach (vecs[i]) begin
            toggle_pulse = vecs[i].toggle;
            snooze_pulse = vecs[i].snooze;
            tick         = vecs[i].tick;
            set_time(int'(vecs[i].h), int'(vecs[i].m), int'(vecs[i].s));
            step();
            chk($sformatf("vec%0d_status", i), int'({al_on, ringing, snoozing}), int'(vecs[i].exp));
        end
        toggle_pulse = 1'b0; snooze_pulse = 1'b0; tick = 1'b0;

        // Ring cadence and unattended timeout.
        trigger_ring("cad");
        for (int k = 0; k < 5; k++) one_second(gate_on(k), $sformatf("cad_s%0d", k));
        chk("timeout_ringing", int'(ringing), 0);
        chk("timeout_al_on", int'(al_on), 1);
        chk("timeout_buzzer", int'(buzzer_out), 0);
        begin
            int rings = 0, buzz = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (ringing) rings++;
                if (buzzer_out) buzz++;
            end
            chk("no_retrigger_ring", rings, 0);
            chk("no_retrigger_buzz", buzz, 0);
        end

        // Snooze during an audible second, then re-ring with a fresh count.
        trigger_ring("snz");
        one_second(gate_on(0), "snz_r0");
        one_second(gate_on(1), "snz_r1");
        begin
            int waited = 0;
            while (!buzzer_out && waited < 10) begin
                step();
                waited++;
            end
            chk("buzz_before_snooze", int'(buzzer_out), 1);
        end
        snooze_pulse = 1'b1;
        step();
        snooze_pulse = 1'b0;
        chk("snooze_snoozing", int'(snoozing), 1);
        chk("snooze_ringing", int'(ringing), 0);
        chk("snooze_buzzer", int'(buzzer_out), 0);
        for (int k = 0; k < 3; k++) one_second(1'b0, $sformatf("snz_q%0d", k));
        chk("rering_ringing", int'(ringing), 1);
        chk("rering_snoozing", int'(snoozing), 0);
        for (int k = 0; k < 4; k++) one_second(gate_on(k), $sformatf("rering_s%0d", k));
        chk("rering_still_ringing", int'(ringing), 1);
        one_second(gate_on(4), "rering_s4");
        chk("rering_timeout_ringing", int'(ringing), 0);
        chk("rering_timeout_al_on", int'(al_on), 1);

        // Reset mid-ring, then a fresh match must not ring.
        trigger_ring("rst");
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        step();
        chk("rst_ring_outputs", int'({al_on, ringing, snoozing, buzzer_out}), 0);
        reset = 1'b0;
        set_time(3, 15, 1);
        step();
        set_time(3, 15, 0);
        step();
        step();
        chk("rst_no_ring", int'({al_on, ringing}), 0);

        // Reset mid-snooze.
        toggle_pulse = 1'b1;
        step();
        toggle_pulse = 1'b0;
        trigger_ring("rst2");
        snooze_pulse = 1'b1;
        step();
        snooze_pulse = 1'b0;
        chk("rst2_snoozing", int'(snoozing), 1);
        reset = 1'b1;
        step();
        chk("rst_snooze_outputs", int'({al_on, ringing, snoozing, buzzer_out}), 0);
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
